fb_rect_fill: RTL and testbench
===============================

# fb_rect_fill

Host-programmable rectangle fill engine that sits directly upstream of the VGA pixel framebuffer and drives its write port. Software loads a rectangle (x, y, width, height, 8-bit intensity) through an Avalon memory-mapped slave and starts it. The engine then emits one framebuffer write per clock, in raster order, until the rectangle is painted. It replaces the per-pixel register pokes the host would otherwise issue.

## Interface
Parameters:
- HRES, 640, visible columns; also the framebuffer row stride.
- VRES, 480, visible rows.
- ADDR_W, 19, framebuffer address width.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  4  register index.
- writedata  in  8  register write data.
- readdata  out  8  status read data (combinational, zero wait states).
- address_write  out  ADDR_W  framebuffer write address.
- data_in  out  DATA_W  framebuffer write data.
- write_ena  out  1  framebuffer write strobe; one pixel per asserted cycle.
- busy  out  1  high from start until the DONE state exits.
- done  out  1  one-cycle pulse at completion or rejection.

## Operation
- Register writes require chipselect && write.
  - 0: x_hi[2:0]. 1: x_lo. 2: y_hi[2:0]. 3: y_lo.
  - 4: w_hi[2:0]. 5: w_lo. 6: h_hi[2:0]. 7: h_lo.
  - 8: color. 9: go (data ignored). 10–15: no effect.
  - Coordinates and sizes are 11 bits: {hi[2:0], lo}.
- readdata at any address = {6'b0, err, busy}.
- All register writes, including go, are ignored while busy.
- States:
  - IDLE: on go, go to SETUP and set busy.
  - SETUP (1 cycle): compute the effective width and height, row_base = y*HRES + x, and clear err.
    - If the effective width or height is 0, go to DONE.
    - Otherwise go to FILL.
  - FILL: assert write_ena each cycle with address_write = row_base + col and data_in = color.
    - Increment col each cycle.
    - At col == ew-1: set col = 0, add HRES to row_base, increment row.
    - At the last pixel (row == eh-1, col == ew-1), go to DONE.
  - DONE (1 cycle): pulse done, deassert busy, go to IDLE.
- No multiplier is used in FILL. The only multiply is the single one in SETUP.
- Address arithmetic is ADDR_W wide. Address values never exceed HRES*VRES-1.
- Reset values:
  - Outputs: write_ena=0, busy=0, done=0, address_write=0, data_in=0.
  - Registers: all 0. err=0. State = IDLE.
- Reset asserted mid-FILL: write_ena drops immediately (asynchronously), the command is lost, and no further writes occur.

## Timing
- go accepted at rising edge N:
  - SETUP is in cycle N+1.
  - The first write_ena is in cycle N+2.
  - The last write_ena is in cycle N+1+ew*eh.
  - done pulses in the cycle after the last write.
  - busy falls on the edge after done.
- Total occupancy is ew*eh + 2 cycles.
- A zero-area command: busy for 2 cycles, done pulses, no writes.
- write_ena is never back-pressured. The framebuffer accepts one write per clock.

## Configuration
- FB_RECT_CLIP_EN defined:
  - ew = min(w, HRES-x) and eh = min(h, VRES-y).
  - x >= HRES or y >= VRES gives zero area.
  - err is never set.
- FB_RECT_CLIP_EN undefined:
  - If x+w > HRES or y+h > VRES, SETUP sets err and goes straight to DONE with no writes.
  - Otherwise ew = w and eh = h.
  - err holds until the next accepted go.

## Structure
- Package fb_pkg holds:
  - HRES/VRES defaults.
  - The register index localparams (REG_X_HI … REG_GO).
  - A state enum typedef fb_fill_state_t {IDLE, SETUP, FILL, DONE}.
  - The status bit positions.
- One sub-module, fb_rect_regs: the Avalon register file plus go decode and the busy lockout. The FSM and address generator stay in the top module.

## Test plan
- x=10, y=20, w=3, h=2, color=0xAA, go -> 6 writes to addresses 12810,12811,12812,13450,13451,13452 with data 0xAA. First write 2 cycles after go. done 1 cycle after the last write.
- w=0, h=5, go -> no write_ena, busy high 2 cycles, done pulses once.
- With clip: x=638, y=479, w=4, h=4 -> exactly 2 writes, at 307198 and 307199. Without clip: no writes, readdata=0x02 after done.
- During FILL, write x_lo=0 and go -> ignored; the original rectangle completes unchanged and readdata bit0=1 throughout.
- reset_n pulled low mid-FILL of a 100x100 rectangle -> write_ena=0 in the same cycle. After release: busy=0, readdata=0, no writes.
- Two back-to-back commands with go issued the cycle after done -> second rectangle's first write at go+2, no gap errors.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the rectangle fill engine: raster defaults, register map,
// FSM state encoding and status bit positions.
package fb_pkg;

    localparam int HRES_DEF = 640;
    localparam int VRES_DEF = 480;

    localparam logic [3:0] REG_X_HI  = 4'd0;
    localparam logic [3:0] REG_X_LO  = 4'd1;
    localparam logic [3:0] REG_Y_HI  = 4'd2;
    localparam logic [3:0] REG_Y_LO  = 4'd3;
    localparam logic [3:0] REG_W_HI  = 4'd4;
    localparam logic [3:0] REG_W_LO  = 4'd5;
    localparam logic [3:0] REG_H_HI  = 4'd6;
    localparam logic [3:0] REG_H_LO  = 4'd7;
    localparam logic [3:0] REG_COLOR = 4'd8;
    localparam logic [3:0] REG_GO    = 4'd9;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fb_fill_state_t;

    function automatic logic [10:0] fb_min11(input logic [10:0] a, input logic [10:0] b);
        fb_min11 = (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fb_rect_regs.sv
// Avalon-MM register file for the fill engine: rectangle/color registers, go decode,
// busy lockout of all writes, and the combinational status read.
module fb_rect_regs
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [7:0]  writedata,
    input  logic        busy,
    input  logic        err,
    output logic [7:0]  readdata,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [10:0] w,
    output logic [10:0] h,
    output logic [7:0]  color,
    output logic        go
);

    logic        wr_en_s;
    logic [10:0] x_r;
    logic [10:0] y_r;
    logic [10:0] w_r;
    logic [10:0] h_r;
    logic [7:0]  color_r;

    assign wr_en_s = chipselect && write && !busy;
    assign go      = wr_en_s && (address == REG_GO);
    assign x       = x_r;
    assign y       = y_r;
    assign w       = w_r;
    assign h       = h_r;
    assign color   = color_r;

    // Register file; the go index and unused indices store nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r     <= 11'd0;
            y_r     <= 11'd0;
            w_r     <= 11'd0;
            h_r     <= 11'd0;
            color_r <= 8'd0;
        end else if (wr_en_s) begin
            case (address)
                REG_X_HI:  x_r[10:8] <= writedata[2:0];
                REG_X_LO:  x_r[7:0]  <= writedata;
                REG_Y_HI:  y_r[10:8] <= writedata[2:0];
                REG_Y_LO:  y_r[7:0]  <= writedata;
                REG_W_HI:  w_r[10:8] <= writedata[2:0];
                REG_W_LO:  w_r[7:0]  <= writedata;
                REG_H_HI:  h_r[10:8] <= writedata[2:0];
                REG_H_LO:  h_r[7:0]  <= writedata;
                REG_COLOR: color_r   <= writedata;
                default:   color_r   <= color_r;
            endcase
        end
    end

    // Status word, returned at every address during a read.
    always_comb begin
        readdata = 8'd0;
        if (chipselect && read) begin
            readdata[STAT_BUSY_BIT] = busy;
            readdata[STAT_ERR_BIT]  = err;
        end else begin
            readdata = 8'd0;
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: one framebuffer write per clock in raster order.
// Define FB_RECT_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int HRES   = HRES_DEF,
    parameter int VRES   = VRES_DEF,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [3:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic [ADDR_W-1:0] address_write,
    output logic [DATA_W-1:0] data_in,
    output logic              write_ena,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] HRES_A  = ADDR_W'(HRES);
    localparam logic [11:0]       HRES_12 = 12'(HRES);
    localparam logic [11:0]       VRES_12 = 12'(VRES);

    fb_fill_state_t    state_r, state_next_s;
    logic [10:0]       x_s, y_s, w_s, h_s;
    logic [7:0]        color_s;
    logic              go_s;
    logic              err_r, err_next_s;
    logic [10:0]       ew_r, ew_next_s, eh_r, eh_next_s;
    logic [10:0]       col_r, col_next_s, row_r, row_next_s;
    logic [ADDR_W-1:0] row_base_r, row_base_next_s, addr_next_s, base_calc_s;
    logic [DATA_W-1:0] data_next_s;
    logic [10:0]       ew_calc_s, eh_calc_s;
    logic              area_err_s;
    logic [ADDR_W-1:0] address_write_r;
    logic [DATA_W-1:0] data_in_r;
    logic              write_ena_r, busy_r, done_r;

    fb_rect_regs u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .busy       (busy_r),
        .err        (err_r),
        .readdata   (readdata),
        .x          (x_s),
        .y          (y_s),
        .w          (w_s),
        .h          (h_s),
        .color      (color_s),
        .go         (go_s)
    );

    assign base_calc_s   = ADDR_W'(y_s) * HRES_A + ADDR_W'(x_s);
    assign address_write = address_write_r;
    assign data_in       = data_in_r;
    assign write_ena     = write_ena_r;
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef FB_RECT_CLIP_EN
    logic [10:0] x_room_s, y_room_s;

    // Effective size clipped to the visible area; off-screen origins give zero area.
    always_comb begin
        x_room_s   = 11'd0;
        y_room_s   = 11'd0;
        area_err_s = 1'b0;
        if ({1'b0, x_s} >= HRES_12) begin
            x_room_s = 11'd0;
        end else begin
            x_room_s = 11'(HRES_12 - {1'b0, x_s});
        end
        if ({1'b0, y_s} >= VRES_12) begin
            y_room_s = 11'd0;
        end else begin
            y_room_s = 11'(VRES_12 - {1'b0, y_s});
        end
        ew_calc_s = fb_min11(w_s, x_room_s);
        eh_calc_s = fb_min11(h_s, y_room_s);
    end
`else
    // Rectangles reaching past the screen edge are rejected outright.
    always_comb begin
        ew_calc_s  = w_s;
        eh_calc_s  = h_s;
        area_err_s = (({1'b0, x_s} + {1'b0, w_s}) > HRES_12) ||
                     (({1'b0, y_s} + {1'b0, h_s}) > VRES_12);
    end
`endif

    // Next-state and datapath update; address steps by +1 per pixel and +HRES per row.
    always_comb begin
        state_next_s    = state_r;
        err_next_s      = err_r;
        ew_next_s       = ew_r;
        eh_next_s       = eh_r;
        col_next_s      = col_r;
        row_next_s      = row_r;
        row_base_next_s = row_base_r;
        addr_next_s     = address_write_r;
        data_next_s     = data_in_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                err_next_s  = area_err_s;
                ew_next_s   = ew_calc_s;
                eh_next_s   = eh_calc_s;
                col_next_s  = 11'd0;
                row_next_s  = 11'd0;
                data_next_s = DATA_W'(color_s);
                if (area_err_s || (ew_calc_s == 11'd0) || (eh_calc_s == 11'd0)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s    = FILL;
                    row_base_next_s = base_calc_s;
                    addr_next_s     = base_calc_s;
                end
            end
            FILL: begin
                if (col_r == (ew_r - 11'd1)) begin
                    if (row_r == (eh_r - 11'd1)) begin
                        // Hold the address so it never steps past the framebuffer.
                        state_next_s = DONE;
                    end else begin
                        state_next_s    = FILL;
                        col_next_s      = 11'd0;
                        row_next_s      = row_r + 11'd1;
                        row_base_next_s = row_base_r + HRES_A;
                        addr_next_s     = row_base_r + HRES_A;
                    end
                end else begin
                    state_next_s = FILL;
                    col_next_s   = col_r + 11'd1;
                    addr_next_s  = address_write_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r           <= 1'b0;
            ew_r            <= 11'd0;
            eh_r            <= 11'd0;
            col_r           <= 11'd0;
            row_r           <= 11'd0;
            row_base_r      <= '0;
            address_write_r <= '0;
            data_in_r       <= '0;
            write_ena_r     <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            err_r           <= err_next_s;
            ew_r            <= ew_next_s;
            eh_r            <= eh_next_s;
            col_r           <= col_next_s;
            row_r           <= row_next_s;
            row_base_r      <= row_base_next_s;
            address_write_r <= addr_next_s;
            data_in_r       <= data_next_s;
            write_ena_r     <= (state_next_s == FILL);
            busy_r          <= (state_next_s != IDLE);
            done_r          <= (state_next_s == DONE);
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: hand-computed write addresses, latencies and status.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [3:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [18:0] address_write;
    logic [7:0]  data_in;
    logic        write_ena;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [18:0] q_addr[$];
    logic [7:0]  q_data[$];
    int first_k, last_k, done_k, done_cnt, busy_cnt, rd_cnt;
    bit timed_out;
    int bad_data;
    int wr_seen, busy_seen;

    fb_rect_fill dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .chipselect    (chipselect),
        .write         (write),
        .read          (read),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .address_write (address_write),
        .data_in       (data_in),
        .write_ena     (write_ena),
        .busy          (busy),
        .done          (done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] wr_addr(input int i);
        if (i < q_addr.size()) return q_addr[i];
        else return 19'h7FFFF;
    endfunction

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic set_rect(input int x, input int y, input int w, input int h);
        reg_wr(4'd0, 8'(x >> 8)); reg_wr(4'd1, 8'(x & 255));
        reg_wr(4'd2, 8'(y >> 8)); reg_wr(4'd3, 8'(y & 255));
        reg_wr(4'd4, 8'(w >> 8)); reg_wr(4'd5, 8'(w & 255));
        reg_wr(4'd6, 8'(h >> 8)); reg_wr(4'd7, 8'(h & 255));
    endtask

    // Issue go now (at a negedge) and record activity per cycle k after the accepting edge.
    task automatic run_cmd(input int max_k, input bit inject);
        q_addr.delete();
        q_data.delete();
        first_k = -1; last_k = -1; done_k = -1;
        done_cnt = 0; busy_cnt = 0; rd_cnt = 0;
        timed_out = 1'b1;
        address = 4'd9;
        write   = 1'b1;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            write = 1'b0;
            if (inject && k == 3) begin
                address = 4'd1; writedata = 8'd0; write = 1'b1;
            end
            if (inject && k == 4) begin
                address = 4'd9; write = 1'b1;
            end
            if (write_ena) begin
                q_addr.push_back(address_write);
                q_data.push_back(data_in);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (busy) busy_cnt++;
            if (readdata[0]) rd_cnt++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        write = 1'b0;
    endtask

    function automatic int count_bad_data(input logic [7:0] exp);
        int n = 0;
        foreach (q_data[i]) if (q_data[i] !== exp) n++;
        return n;
    endfunction

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = 4'd0;
        writedata  = 8'd0;
        repeat (2) @(negedge clk);

        chk("rst_write_ena", {31'd0, write_ena}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_address_write", {13'd0, address_write}, 32'd0);
        chk("rst_data_in", {24'd0, data_in}, 32'd0);
        chk("rst_readdata", {24'd0, readdata}, 32'd0);

        reset_n = 1'b1;
        @(negedge clk);

        // Basic 3x2 rectangle at (10,20).
        set_rect(10, 20, 3, 2);
        reg_wr(4'd8, 8'hAA);
        run_cmd(40, 1'b0);
        chk("t1_timeout", {31'd0, timed_out}, 32'd0);
        chk("t1_nwrites", q_addr.size(), 32'd6);
        chk("t1_addr0", {13'd0, wr_addr(0)}, 32'd12810);
        chk("t1_addr1", {13'd0, wr_addr(1)}, 32'd12811);
        chk("t1_addr2", {13'd0, wr_addr(2)}, 32'd12812);
        chk("t1_addr3", {13'd0, wr_addr(3)}, 32'd13450);
        chk("t1_addr4", {13'd0, wr_addr(4)}, 32'd13451);
        chk("t1_addr5", {13'd0, wr_addr(5)}, 32'd13452);
        chk("t1_bad_data", count_bad_data(8'hAA), 32'd0);
        chk("t1_first_k", first_k, 32'd2);
        chk("t1_last_k", last_k, 32'd7);
        chk("t1_done_k", done_k, 32'd8);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_busy_cycles", busy_cnt, 32'd8);
        chk("t1_readdata", {24'd0, readdata}, 32'd0);

        // Zero-width command.
        reg_wr(4'd5, 8'd0);
        reg_wr(4'd7, 8'd5);
        run_cmd(40, 1'b0);
        chk("t2_timeout", {31'd0, timed_out}, 32'd0);
        chk("t2_nwrites", q_addr.size(), 32'd0);
        chk("t2_busy_cycles", busy_cnt, 32'd2);
        chk("t2_done_cnt", done_cnt, 32'd1);
        chk("t2_done_k", done_k, 32'd2);

        // Rectangle hanging off the bottom-right corner.
        set_rect(638, 479, 4, 4);
        run_cmd(40, 1'b0);
        chk("t3_timeout", {31'd0, timed_out}, 32'd0);
`ifdef FB_RECT_CLIP_EN
        chk("t3_nwrites", q_addr.size(), 32'd2);
        chk("t3_addr0", {13'd0, wr_addr(0)}, 32'd307198);
        chk("t3_addr1", {13'd0, wr_addr(1)}, 32'd307199);
        chk("t3_busy_cycles", busy_cnt, 32'd4);
        chk("t3_readdata", {24'd0, readdata}, 32'd0);
`else
        chk("t3_nwrites", q_addr.size(), 32'd0);
        chk("t3_busy_cycles", busy_cnt, 32'd2);
        chk("t3_done_cnt", done_cnt, 32'd1);
        chk("t3_readdata_err", {24'd0, readdata}, 32'h02);
`endif

        // Writes and go during FILL are ignored; err clears on the next command.
        set_rect(10, 20, 3, 2);
        reg_wr(4'd8, 8'h5C);
        run_cmd(40, 1'b1);
        chk("t4_timeout", {31'd0, timed_out}, 32'd0);
        chk("t4_nwrites", q_addr.size(), 32'd6);
        chk("t4_addr0", {13'd0, wr_addr(0)}, 32'd12810);
        chk("t4_addr5", {13'd0, wr_addr(5)}, 32'd13452);
        chk("t4_bad_data", count_bad_data(8'h5C), 32'd0);
        chk("t4_rd_busy_cycles", rd_cnt, 32'd8);
        chk("t4_readdata", {24'd0, readdata}, 32'd0);
        reg_wr(4'd5, 8'd1);
        reg_wr(4'd7, 8'd1);
        run_cmd(40, 1'b0);
        chk("t4_xlo_kept_n", q_addr.size(), 32'd1);
        chk("t4_xlo_kept_addr", {13'd0, wr_addr(0)}, 32'd12810);

        // Back-to-back: second go in the cycle right after done.
        reg_wr(4'd5, 8'd2);
        run_cmd(40, 1'b0);
        chk("t6_a_nwrites", q_addr.size(), 32'd2);
        run_cmd(40, 1'b0);
        chk("t6_b_timeout", {31'd0, timed_out}, 32'd0);
        chk("t6_b_first_k", first_k, 32'd2);
        chk("t6_b_nwrites", q_addr.size(), 32'd2);
        chk("t6_b_addr0", {13'd0, wr_addr(0)}, 32'd12810);
        chk("t6_b_addr1", {13'd0, wr_addr(1)}, 32'd12811);
        chk("t6_b_busy_cycles", busy_cnt, 32'd4);

        // Asynchronous reset in the middle of a 100x100 fill.
        set_rect(0, 0, 100, 100);
        address = 4'd9;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
        repeat (9) @(negedge clk);
        chk("t5_filling", {31'd0, write_ena}, 32'd1);
        #5;
        reset_n = 1'b0;
        #1;
        chk("t5_wena_async", {31'd0, write_ena}, 32'd0);
        chk("t5_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (write_ena) wr_seen++;
            if (busy) busy_seen++;
        end
        chk("t5_no_writes", wr_seen, 32'd0);
        chk("t5_busy_after", busy_seen, 32'd0);
        chk("t5_readdata", {24'd0, readdata}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
